m_spi_control: RTL and testbench

- SPI master (initiator) for the s_spi_control slave; one full-duplex frame per `start`.
- Protocol is mode 0:
  - SS active low.
  - SCLK idles low.
  - MSB first.
  - Master updates MOSI on SCLK falling edges and samples MISO on SCLK rising edges.
- SS returns high after every frame, so the slave latches its received word and reloads its transmit word.
- Sits between a host-side register/FSM and the SPI pins.

---
 rtl/m_spi_control_pkg.sv | 14 +
 rtl/m_spi_control_spi_half_period_timer.sv | 23 ++
 rtl/m_spi_control.sv | 105 ++++++++++
 tb/tb_m_spi_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/m_spi_control_pkg.sv
// rtl/m_spi_control_pkg.sv - shared SPI defaults and FSM state encoding
package m_spi_control_pkg;
  localparam int DEF_DATA_LENGTH = 8;
  localparam int DEF_CLK_DIV     = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;
endpackage

// File: rtl/m_spi_control_spi_half_period_timer.sv
// rtl/m_spi_control_spi_half_period_timer.sv - loadable down-counter, tc while count is zero
module spi_half_period_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign tc = (count == '0);
endmodule

// File: rtl/m_spi_control.sv
// rtl/m_spi_control.sv - mode 0 SPI master, one full-duplex frame per start
module m_spi_control
  import m_spi_control_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int CLK_DIV     = DEF_CLK_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] tx_data,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   SCLK,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic                   SS
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DATA_LENGTH) + 1;
  localparam logic [CW-1:0] N_BITS = CW'(DATA_LENGTH);
  localparam logic [CW-1:0] N_LAST = CW'(DATA_LENGTH - 1);

  state_t                 state;
  logic [DATA_LENGTH-1:0] tx_sr;
  logic [DATA_LENGTH-1:0] rx_sr;
  logic [CW-1:0]          bit_cnt;
  logic                   tc;
  logic                   timer_load;

  // Every non-IDLE state is reloaded on entry so each lasts CLK_DIV cycles.
  assign timer_load = (state == IDLE) ? start : tc;

  spi_half_period_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (TW'(CLK_DIV - 1)),
    .tc         (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      SS      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // MSB goes straight to MOSI; tx_sr keeps the remaining bits top-aligned.
          tx_sr   <= tx_data << 1;
          MOSI    <= tx_data[DATA_LENGTH-1];
          bit_cnt <= '0;
          SS      <= 1'b0;
          busy    <= 1'b1;
          state   <= SETUP;
        end
        SETUP: if (tc) begin
          SCLK  <= 1'b1;
          rx_sr <= {rx_sr[DATA_LENGTH-2:0], MISO};
          state <= SCLK_HI;
        end
        SCLK_HI: if (tc) begin
          SCLK    <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt < N_LAST) begin
            MOSI  <= tx_sr[DATA_LENGTH-1];
            tx_sr <= tx_sr << 1;
          end
          state <= SCLK_LO;
        end
        SCLK_LO: if (tc) begin
          if (bit_cnt < N_BITS) begin
            SCLK  <= 1'b1;
            rx_sr <= {rx_sr[DATA_LENGTH-2:0], MISO};
            state <= SCLK_HI;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: if (tc) begin
          SS    <= 1'b1;
          MOSI  <= 1'b0;
          state <= GAP;
        end
        GAP: if (tc) begin
          done    <= 1'b1;
          busy    <= 1'b0;
          rx_data <= rx_sr;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_spi_control.sv
// tb/tb_m_spi_control.sv - directed bench for m_spi_control with behavioural mode 0 slaves
module tb_m_spi_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sel = 1'b0;

  logic       ss1, sclk1, mosi1, miso1, busy1, done1;
  logic       ss2, sclk2, mosi2, miso2, busy2, done2;
  logic [7:0] rx1, rx2;
  logic       start1, start2;

  logic [7:0] s1_o = 8'h00, s1_i = 8'h00, s1_tx = 8'h00, s1_rx = 8'h00;
  logic [7:0] s2_o = 8'h00, s2_i = 8'h00, s2_tx = 8'h00, s2_rx = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  int ss_fall1, ss_rise1, ss_fall2, rises, falls, first_rise, done_cyc, done_cnt;
  logic [7:0] rx_at, si_first;
  logic busy_at1, mosi_at1;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  m_spi_control #(.DATA_LENGTH(8), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx_data), .rx_data(rx1),
    .busy(busy1), .done(done1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .SS(ss1)
  );

  m_spi_control #(.DATA_LENGTH(8), .CLK_DIV(2)) dut_d2 (
    .clk(clk), .reset(reset), .start(start2), .tx_data(tx_data), .rx_data(rx2),
    .busy(busy2), .done(done2), .SCLK(sclk2), .MOSI(mosi2), .MISO(miso2), .SS(ss2)
  );

  // Mode 0 slave models: load on SS fall, sample on SCLK rise, shift on SCLK fall.
  always @(negedge ss1) s1_tx = s1_o;
  always @(posedge sclk1) if (!ss1) s1_rx = {s1_rx[6:0], mosi1};
  always @(negedge sclk1) if (!ss1) s1_tx = s1_tx << 1;
  always @(posedge ss1) s1_i = s1_rx;
  assign miso1 = ss1 ? 1'b0 : s1_tx[7];

  always @(negedge ss2) s2_tx = s2_o;
  always @(posedge sclk2) if (!ss2) s2_rx = {s2_rx[6:0], mosi2};
  always @(negedge sclk2) if (!ss2) s2_tx = s2_tx << 1;
  always @(posedge ss2) s2_i = s2_rx;
  assign miso2 = ss2 ? 1'b0 : s2_tx[7];

  logic       m_ss, m_sclk, m_mosi, m_busy, m_done;
  logic [7:0] m_rx, m_si;
  assign m_ss   = sel ? ss2   : ss1;
  assign m_sclk = sel ? sclk2 : sclk1;
  assign m_mosi = sel ? mosi2 : mosi1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_rx   = sel ? rx2   : rx1;
  assign m_si   = sel ? s2_i  : s1_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Accepts a frame, then samples cycles 1..limit (#1 after each edge) and records events.
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] tx2, input bit hold,
                           input int pa, input int pb, input int limit);
    logic prev_ss, prev_sclk;
    tx_data = tx;
    start = 1'b1;
    @(posedge clk); #1;
    tx_data = tx2;
    ss_fall1 = -1; ss_rise1 = -1; ss_fall2 = -1;
    rises = 0; falls = 0; first_rise = -1; done_cyc = -1; done_cnt = 0;
    rx_at = 8'h00; si_first = 8'h00; busy_at1 = 1'b0; mosi_at1 = 1'b0;
    prev_ss = 1'b1; prev_sclk = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (c == 1) begin busy_at1 = m_busy; mosi_at1 = m_mosi; end
      if (!m_ss && prev_ss) begin
        if (ss_fall1 < 0) ss_fall1 = c; else if (ss_fall2 < 0) ss_fall2 = c;
      end
      if (m_ss && !prev_ss && ss_rise1 < 0) begin ss_rise1 = c; si_first = m_si; end
      if (m_sclk && !prev_sclk) begin rises++; if (first_rise < 0) first_rise = c; end
      if (!m_sclk && prev_sclk) falls++;
      prev_ss = m_ss;
      prev_sclk = m_sclk;
      if (m_done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; rx_at = m_rx; end
      end
      start = hold ? 1'b1 : (c == pa || c == pb);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    // 1: reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ss", ss1, 1'b1);
    chk("reset_sclk", sclk1, 1'b0);
    chk("reset_mosi", mosi1, 1'b0);
    chk("reset_busy", busy1, 1'b0);
    chk("reset_done", done1, 1'b0);
    chk("reset_rx", rx1, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    // 2: single frame, D=4
    s1_o = 8'h3C;
    run_frame(8'hA5, 8'hA5, 1'b0, -1, -1, 80);
    chk("f1_busy_c1", busy_at1, 1'b1);
    chk("f1_mosi_c1", mosi_at1, 1'b1);
    chk("f1_ss_fall", ss_fall1, 1);
    chk("f1_ss_rise", ss_rise1, 73);
    chk("f1_first_rise", first_rise, 5);
    chk("f1_rises", rises, 8);
    chk("f1_falls", falls, 8);
    chk("f1_done_cyc", done_cyc, 77);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_rx", rx_at, 8'h3C);
    chk("f1_slave_rx", s1_i, 8'hA5);
    chk("f1_sclk_end", sclk1, 1'b0);
    chk("f1_busy_end", busy1, 1'b0);

    // 3: back-to-back with start held
    s1_o = 8'h00;
    run_frame(8'h01, 8'h80, 1'b1, -1, -1, 152);
    chk("b2b_ss_rise", ss_rise1, 73);
    chk("b2b_ss_fall2", ss_fall2, 78);
    chk("b2b_done_cyc", done_cyc, 77);
    chk("b2b_slave_rx0", si_first, 8'h01);
    chk("b2b_slave_rx1", s1_i, 8'h80);
    do_reset();
    @(posedge clk); #1;

    // 4: start during busy ignored; tx_data change after acceptance ignored
    s1_o = 8'hC3;
    run_frame(8'h5A, 8'hFF, 1'b0, 10, 40, 100);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_edges", rises + falls, 16);
    chk("ign_done_cyc", done_cyc, 77);
    chk("ign_rx", rx_at, 8'hC3);
    chk("ign_slave_rx", s1_i, 8'h5A);

    // 5: reset at cycle 20 of a frame, then a clean frame
    s1_o = 8'hC3;
    run_frame(8'h33, 8'h33, 1'b0, -1, -1, 19);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ss", ss1, 1'b1);
    chk("abort_sclk", sclk1, 1'b0);
    chk("abort_done", done1, 1'b0);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_rx", rx1, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_done", done1, 1'b0);
    s1_o = 8'h00;
    run_frame(8'hFF, 8'hFF, 1'b0, -1, -1, 80);
    chk("post_done_cyc", done_cyc, 77);
    chk("post_rx", rx_at, 8'h00);
    chk("post_slave_rx", s1_i, 8'hFF);

    // 6: D=2 corner on the second instance
    sel = 1'b1;
    s2_o = 8'hFF;
    @(posedge clk); #1;
    run_frame(8'h00, 8'h00, 1'b0, -1, -1, 44);
    chk("d2_ss_rise", ss_rise1, 37);
    chk("d2_first_rise", first_rise, 3);
    chk("d2_rises", rises, 8);
    chk("d2_done_cyc", done_cyc, 39);
    chk("d2_rx", rx_at, 8'hFF);
    chk("d2_slave_rx", s2_i, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
